// File: rtl/spi_timing_gen.sv
// Timing generator for the SPI master: serial clock and display refresh dividers,
// plus bit/byte position counters that advance on each sclk rising edge.
module spi_timing_gen #(
  parameter int SCLK_HALF_DIV = 10,
  parameter int DISP_HALF_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_clr,
  input  logic       byte_clr,
  output logic       sclk,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       disp_clk,
  output logic       disp_tick,
  output logic [2:0] bit_cnt,
  output logic [1:0] byte_cnt,
  output logic       byte_last_bit
);

  // Index 0 is the sclk divider, index 1 the display refresh divider.
  logic [1:0] wrap;
  logic [1:0] div_clk;
  logic [1:0] div_rise;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_div
      localparam int HALF = (gi == 0) ? SCLK_HALF_DIV : DISP_HALF_DIV;
      localparam int CW   = $clog2(HALF) + 1;

      logic [CW-1:0] cnt_reg;
      logic          clk_reg;
      logic          rise_reg;

      assign wrap[gi]     = (cnt_reg == CW'(HALF - 1));
      assign div_clk[gi]  = clk_reg;
      assign div_rise[gi] = rise_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          clk_reg  <= 1'b0;
          rise_reg <= 1'b0;
        end else begin
          cnt_reg  <= wrap[gi] ? '0 : cnt_reg + CW'(1);
          clk_reg  <= wrap[gi] ? ~clk_reg : clk_reg;
          rise_reg <= wrap[gi] & ~clk_reg;
        end
      end
    end
  endgenerate

  logic       sclk_fall_reg;
  logic       tick;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [1:0] byte_cnt_reg, byte_cnt_next;

  // The counters update on the same clk edge where sclk goes 0->1.
  assign tick = wrap[0] & ~div_clk[0];

  always_comb begin
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    if (tick) begin
      if (cnt_clr) begin
        bit_cnt_next  = 3'd0;
        byte_cnt_next = 2'd0;
      end else begin
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (byte_clr)
          byte_cnt_next = 2'd0;
        else if (bit_cnt_reg == 3'd7)
          byte_cnt_next = byte_cnt_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_fall_reg <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      byte_cnt_reg  <= 2'd0;
    end else begin
      sclk_fall_reg <= wrap[0] & div_clk[0];
      bit_cnt_reg   <= bit_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
    end
  end

  assign sclk          = div_clk[0];
  assign sclk_rise     = div_rise[0];
  assign sclk_fall     = sclk_fall_reg;
  assign disp_clk      = div_clk[1];
  assign disp_tick     = div_rise[1];
  assign bit_cnt       = bit_cnt_reg;
  assign byte_cnt      = byte_cnt_reg;
  assign byte_last_bit = (bit_cnt_reg == 3'd7);

endmodule

// File: tb/tb_spi_timing_gen.sv
// Bench for spi_timing_gen: divider waveform table after reset, counter
// scoreboard across sclk ticks, clear priority, and asynchronous reset mid-byte.
module tb_spi_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       byte_clr = 1'b0;
  logic       sclk, sclk_rise, sclk_fall, disp_clk, disp_tick, byte_last_bit;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;

  spi_timing_gen #(.SCLK_HALF_DIV(10), .DISP_HALF_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr), .byte_clr(byte_clr),
    .sclk(sclk), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .disp_clk(disp_clk), .disp_tick(disp_tick),
    .bit_cnt(bit_cnt), .byte_cnt(byte_cnt), .byte_last_bit(byte_last_bit)
  );

  always #5 clk = ~clk;

  // clk edges since reset release; edge 1 is the first rising edge after release
  int ec;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int       cyc;
    bit       sclk, rise, fall, disp, dtick;
    bit [2:0] bitc;
  } vec_t;

  typedef struct {
    bit [2:0] b;
    bit [1:0] y;
    bit       last;
  } exp_t;

  exp_t     sb[$];
  bit [2:0] mb;
  bit [1:0] my;

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (sclk_rise) ok = 1'b1;
    end
  endtask

  // Drive clear inputs for exactly one tick; model the expected counters and check.
  task automatic do_tick(input bit c, input bit b);
    exp_t e, g;
    bit   ok;
    @(negedge clk);
    cnt_clr  = c;
    byte_clr = b;
    if (c) begin
      mb = 3'd0;
      my = 2'd0;
    end else begin
      if (b)              my = 2'd0;
      else if (mb == 3'd7) my = my + 2'd1;
      mb = mb + 3'd1;
    end
    e.b = mb; e.y = my; e.last = (mb == 3'd7);
    sb.push_back(e);
    wait_rise(ok);
    chk("tick_timeout", int'(ok), 1);
    g = sb.pop_front();
    chk("bit_cnt", int'(bit_cnt), int'(g.b));
    chk("byte_cnt", int'(byte_cnt), int'(g.y));
    chk("byte_last_bit", int'(byte_last_bit), int'(g.last));
    $display("tick clr=%0b bclr=%0b -> bit=%0d byte=%0d last=%0b (exp %0d/%0d)",
             c, b, bit_cnt, byte_cnt, byte_last_bit, g.b, g.y);
    @(negedge clk);
    cnt_clr  = 1'b0;
    byte_clr = 1'b0;
  endtask

  vec_t vec[16];
  bit   both_seen;
  bit   ok;

  initial begin
    vec[0]  = '{4,  0, 0, 0, 1, 1, 0};
    vec[1]  = '{5,  0, 0, 0, 1, 0, 0};
    vec[2]  = '{8,  0, 0, 0, 0, 0, 0};
    vec[3]  = '{9,  0, 0, 0, 0, 0, 0};
    vec[4]  = '{10, 1, 1, 0, 0, 0, 1};
    vec[5]  = '{11, 1, 0, 0, 0, 0, 1};
    vec[6]  = '{12, 1, 0, 0, 1, 1, 1};
    vec[7]  = '{19, 1, 0, 0, 0, 0, 1};
    vec[8]  = '{20, 0, 0, 1, 1, 1, 1};
    vec[9]  = '{21, 0, 0, 0, 1, 0, 1};
    vec[10] = '{30, 1, 1, 0, 1, 0, 2};
    vec[11] = '{31, 1, 0, 0, 1, 0, 2};
    vec[12] = '{40, 0, 0, 1, 0, 0, 2};
    vec[13] = '{50, 1, 1, 0, 0, 0, 3};
    vec[14] = '{52, 1, 0, 0, 1, 1, 3};
    vec[15] = '{60, 0, 0, 1, 1, 1, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_rise", int'(sclk_rise), 0);
    chk("rst_fall", int'(sclk_fall), 0);
    chk("rst_disp", int'(disp_clk), 0);
    chk("rst_dtick", int'(disp_tick), 0);
    chk("rst_bit", int'(bit_cnt), 0);
    chk("rst_byte", int'(byte_cnt), 0);
    #1 rst_n = 1'b1;

    // Divider waveform table over the first 60 edges
    both_seen = 1'b0;
    for (int e = 1, k = 0; e <= 60; e++) begin
      @(posedge clk); #1;
      if (sclk_rise && sclk_fall) both_seen = 1'b1;
      if (k < 16 && vec[k].cyc == ec) begin
        chk($sformatf("e%0d_sclk", ec), int'(sclk), int'(vec[k].sclk));
        chk($sformatf("e%0d_rise", ec), int'(sclk_rise), int'(vec[k].rise));
        chk($sformatf("e%0d_fall", ec), int'(sclk_fall), int'(vec[k].fall));
        chk($sformatf("e%0d_disp", ec), int'(disp_clk), int'(vec[k].disp));
        chk($sformatf("e%0d_dtick", ec), int'(disp_tick), int'(vec[k].dtick));
        chk($sformatf("e%0d_bit", ec), int'(bit_cnt), int'(vec[k].bitc));
        chk($sformatf("e%0d_byte", ec), int'(byte_cnt), 0);
        $display("edge %0d: sclk=%0b rise=%0b fall=%0b disp=%0b dtick=%0b bit=%0d",
                 ec, sclk, sclk_rise, sclk_fall, disp_clk, disp_tick, bit_cnt);
        k++;
      end
    end
    chk("rise_fall_exclusive", int'(both_seen), 0);

    // Counter sequences through the scoreboard
    mb = 3'd3; my = 2'd0;
    do_tick(1, 0);                              // 0/0
    for (int i = 0; i < 32; i++) do_tick(0, 0); // 1..7,0 then wrap to 0/0
    for (int i = 0; i < 19; i++) do_tick(0, 0); // 3/2
    do_tick(0, 1);                              // 4/0
    for (int i = 0; i < 9; i++) do_tick(0, 0);  // 5/1
    do_tick(1, 1);                              // 0/0
    do_tick(0, 0);
    do_tick(0, 0);                              // 2/0

    // Clears held between ticks: counters hold, display divider unaffected
    cnt_clr  = 1'b1;
    byte_clr = 1'b1;
    repeat (14) begin
      @(posedge clk); #1;
      chk("hold_dtick", int'(disp_tick), int'((ec % 8) == 4));
      chk("hold_bit", int'(bit_cnt), int'(mb));
      chk("hold_byte", int'(byte_cnt), int'(my));
    end
    @(negedge clk);
    cnt_clr  = 1'b0;
    byte_clr = 1'b0;
    do_tick(0, 0);                              // 3/0
    for (int i = 0; i < 19; i++) do_tick(0, 0); // 6/2

    // Asynchronous reset mid-byte with sclk high
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_sclk", int'(sclk), 1);
    chk("pre_rst_bit", int'(bit_cnt), 6);
    chk("pre_rst_byte", int'(byte_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_sclk", int'(sclk), 0);
    chk("arst_bit", int'(bit_cnt), 0);
    chk("arst_byte", int'(byte_cnt), 0);
    chk("arst_disp", int'(disp_clk), 0);
    $display("async reset: sclk=%0b bit=%0d byte=%0d disp=%0b", sclk, bit_cnt, byte_cnt, disp_clk);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mb = 3'd0; my = 2'd0;
    wait_rise(ok);
    chk("rerun_timeout", int'(ok), 1);
    chk("rerun_first_rise_edge", ec, 10);
    chk("rerun_bit", int'(bit_cnt), 1);
    chk("rerun_byte", int'(byte_cnt), 0);
    $display("after release: first rise at edge %0d bit=%0d", ec, bit_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
